rv_mc_ctrl: RTL and testbench
=============================

# rv_mc_ctrl

Multicycle control sequencer for the RV32I core's fetch/execute/memory/writeback datapath. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It drives the writeback and next-PC select lines (MemtoReg, storeJalr, wbToReg, selUtype, Branch, selJalOrJalr) and the register-file, PC and memory strobes. It also handles wait-states on instruction and data memory, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_i  in  32  instruction word, valid when imem_ready_i=1 in FETCH
- imem_ready_i  in  1  instruction memory data valid
- dmem_ready_i  in  1  data memory access complete
- ex_branch_i  in  1  branch condition from ALU compare
- imem_req_o  out  1  instruction fetch request
- ir_we_o  out  1  load instruction register
- dmem_re_o / dmem_we_o  out  1  data memory read / write request
- rf_we_o  out  1  register file write enable
- pc_we_o  out  1  PC update strobe
- pc_src_o  out  1  0: take wb_to_if0 (seq/branch), 1: take wb_to_if1 (jump)
- MemtoReg  out  4  load extension select
- storeJalr, wbToReg, selUtype, Branch, selJalOrJalr  out  1 each  writeback/next-PC selects
- trap_o  out  1  illegal opcode seen, core halted
- instret_o  out  CNT_W  retired instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req_o=1; stay until imem_ready_i; on ready, ir_we_o=1 and go to DECODE.
- DECODE: decode opcode/funct3 of the IR copy and latch all select fields. Illegal opcode → TRAP.
- EXEC: LOAD/STORE → MEM; all others → WB.
- MEM: dmem_re_o (load) or dmem_we_o (store) held high until dmem_ready_i; the ready cycle exits to WB.
- WB: rf_we_o=1 for all classes except BRANCH and STORE. pc_we_o=1 always. instret_o increments by 1. Next state is FETCH.
- TRAP: trap_o=1, every strobe 0, absorbing until reset.
- Decode (opcode → latched fields; unlisted fields are 0):
  - LUI 0110111: wbToReg=1, selUtype=0.
  - AUIPC 0010111: wbToReg=1, selUtype=1.
  - JAL 1101111: storeJalr=1, pc_src=1, selJalOrJalr=0.
  - JALR 1100111: storeJalr=1, pc_src=1, selJalOrJalr=1.
  - BRANCH 1100011: Branch=1.
  - LOAD 0000011: MemtoReg by funct3: LB 000→0001, LH 001→0011, LW 010→0101, LBU 100→1001, LHU 101→1011. Any other funct3 → TRAP.
  - STORE 0100011, OP-IMM 0010011, OP 0110011: MemtoReg=0000.
- Branch resolution stays in the datapath: ex_branch_i&Branch selects wb_to_if0. The controller only asserts Branch.
- The instret counter wraps from all-ones to 0 without flagging.

## Timing
- Reset values: state FETCH; every strobe 0; MemtoReg=0000; all selects 0; trap_o=0; instret_o=0.
- Latched select fields are stable from the cycle after DECODE through WB. They change only in DECODE.
- Zero-wait latency, FETCH entry to pc_we_o:
  - ALU/U/J/branch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- Each imem or dmem wait cycle adds one cycle.
- pc_we_o and rf_we_o are single-cycle pulses, exactly one pc_we_o per retired instruction.
- Memory ready high in the same cycle as its request counts as a 0-wait access. Ready seen outside FETCH/MEM is ignored.
- Asynchronous reset mid-instruction aborts the instruction. No pulse occurs in the reset cycle, instret_o is cleared, and the FSM restarts in FETCH on the first edge after release.
- All strobes are decoded from the registered state only, so they are glitch-free and contain no input-to-output combinational path. The only exceptions are ir_we_o and the MEM exit, which gate on the ready inputs.

## Structure
- Shared package rv_ctrl_pkg holds:
  - opcode localparams;
  - the state enum;
  - MemtoReg codes (MTR_ALU, MTR_LB, MTR_LH, MTR_LW, MTR_LBU, MTR_LHU).
- One combinational sub-module, rv_ctrl_decode, maps (opcode, funct3) to the select bundle plus illegal, is_mem and is_store flags.
- The top module holds the FSM, the latched select register and the instret counter.

## Test plan
- ADDI with both readies tied high → pc_we_o at cycle 4, rf_we_o same cycle, instret_o 0→1, MemtoReg=0000.
- LHU with dmem_ready_i low for 3 MEM cycles:
  - dmem_re_o high for 4 cycles;
  - MemtoReg=1011 from EXEC through WB;
  - pc_we_o at cycle 8.
- Sequential-select checks:
  - JALR → storeJalr=1, selJalOrJalr=1, pc_src_o=1, rf_we_o=1.
  - AUIPC → wbToReg=1, selUtype=1.
- SW, then BEQ:
  - both give rf_we_o=0 in WB;
  - SW gives dmem_we_o=1 in MEM;
  - BEQ gives Branch=1 and pc_src_o=0.
- Opcode 1111111 → TRAP after DECODE, trap_o=1. Feeding further instructions gives no strobes and no instret increment, until rst_n pulses low.
- Asynchronous reset and counter wrap:
  - rst_n low during MEM of a load → all outputs at reset values immediately, with no rf_we_o.
  - instret_o preloaded (force) to all-ones wraps to 0 on the next retirement.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, state encoding and select bundle for the multicycle controller
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [3:0] MTR_ALU = 4'b0000;
    localparam logic [3:0] MTR_LB  = 4'b0001;
    localparam logic [3:0] MTR_LH  = 4'b0011;
    localparam logic [3:0] MTR_LW  = 4'b0101;
    localparam logic [3:0] MTR_LBU = 4'b1001;
    localparam logic [3:0] MTR_LHU = 4'b1011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // rf_write is carried with the selects so WB needs no second decode
    typedef struct packed {
        logic [3:0] mem_to_reg;
        logic       store_jalr;
        logic       wb_to_reg;
        logic       sel_utype;
        logic       branch;
        logic       sel_jal_or_jalr;
        logic       pc_src;
        logic       rf_write;
    } sel_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// rtl/rv_ctrl_decode.sv - combinational opcode/funct3 decoder producing the select bundle
module rv_ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output sel_t       sel,
    output logic       illegal,
    output logic       is_mem,
    output logic       is_store
);

    // map opcode/funct3 to selects; an illegal encoding forces an all-zero bundle
    always_comb begin
        sel            = '0;
        sel.mem_to_reg = MTR_ALU;
        illegal        = 1'b0;
        is_mem         = 1'b0;
        is_store       = 1'b0;
        case (opcode)
            OP_LUI: begin
                sel.wb_to_reg = 1'b1;
                sel.rf_write  = 1'b1;
            end
            OP_AUIPC: begin
                sel.wb_to_reg = 1'b1;
                sel.sel_utype = 1'b1;
                sel.rf_write  = 1'b1;
            end
            OP_JAL: begin
                sel.store_jalr = 1'b1;
                sel.pc_src     = 1'b1;
                sel.rf_write   = 1'b1;
            end
            OP_JALR: begin
                sel.store_jalr      = 1'b1;
                sel.pc_src          = 1'b1;
                sel.sel_jal_or_jalr = 1'b1;
                sel.rf_write        = 1'b1;
            end
            OP_BRANCH: begin
                sel.branch = 1'b1;
            end
            OP_LOAD: begin
                is_mem       = 1'b1;
                sel.rf_write = 1'b1;
                case (funct3)
                    3'b000:  sel.mem_to_reg = MTR_LB;
                    3'b001:  sel.mem_to_reg = MTR_LH;
                    3'b010:  sel.mem_to_reg = MTR_LW;
                    3'b100:  sel.mem_to_reg = MTR_LBU;
                    3'b101:  sel.mem_to_reg = MTR_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_IMM, OP_OP: begin
                sel.rf_write = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            sel      = '0;
            is_mem   = 1'b0;
            is_store = 1'b0;
        end
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// rtl/rv_mc_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             ex_branch_i,
    output logic             imem_req_o,
    output logic             ir_we_o,
    output logic             dmem_re_o,
    output logic             dmem_we_o,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic [3:0]       MemtoReg,
    output logic             storeJalr,
    output logic             wbToReg,
    output logic             selUtype,
    output logic             Branch,
    output logic             selJalOrJalr,
    output logic             trap_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t           state;
    logic             active_q;
    logic [9:0]       ir_q;
    sel_t             sel_q;
    logic             is_mem_q;
    logic             is_store_q;
    logic [CNT_W-1:0] instret_q;

    sel_t             dec_sel;
    logic             dec_illegal;
    logic             dec_is_mem;
    logic             dec_is_store;

    // operand/immediate bits live in the datapath; branch resolution happens there too
    logic             unused_inputs;
    assign unused_inputs = ^{instr_i[31:15], instr_i[11:7], ex_branch_i};

    rv_ctrl_decode u_decode (
        .opcode   (ir_q[6:0]),
        .funct3   (ir_q[9:7]),
        .sel      (dec_sel),
        .illegal  (dec_illegal),
        .is_mem   (dec_is_mem),
        .is_store (dec_is_store)
    );

    // sequencer; active_q keeps FETCH quiet until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            active_q   <= 1'b0;
            ir_q       <= '0;
            sel_q      <= '0;
            is_mem_q   <= 1'b0;
            is_store_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            active_q <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (active_q && imem_ready_i) begin
                        ir_q  <= {instr_i[14:12], instr_i[6:0]};
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    sel_q      <= dec_sel;
                    is_mem_q   <= dec_is_mem;
                    is_store_q <= dec_is_store;
                    state      <= dec_illegal ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    state <= is_mem_q ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ready_i) begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    instret_q <= instret_q + CNT_W'(1);
                    state     <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

    assign imem_req_o   = active_q && (state == S_FETCH);
    assign ir_we_o      = imem_req_o && imem_ready_i;
    assign dmem_re_o    = (state == S_MEM) && !is_store_q;
    assign dmem_we_o    = (state == S_MEM) && is_store_q;
    assign rf_we_o      = (state == S_WB) && sel_q.rf_write;
    assign pc_we_o      = (state == S_WB);
    assign trap_o       = (state == S_TRAP);
    assign pc_src_o     = sel_q.pc_src;
    assign MemtoReg     = sel_q.mem_to_reg;
    assign storeJalr    = sel_q.store_jalr;
    assign wbToReg      = sel_q.wb_to_reg;
    assign selUtype     = sel_q.sel_utype;
    assign Branch       = sel_q.branch;
    assign selJalOrJalr = sel_q.sel_jal_or_jalr;
    assign instret_o    = instret_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb/tb_rv_mc_ctrl.sv - table-driven and sequence checks for rv_mc_ctrl
module tb_rv_mc_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      instr_i = '0;
    logic             imem_ready_i = 1'b0;
    logic             dmem_ready_i = 1'b0;
    logic             ex_branch_i = 1'b0;
    logic             imem_req_o, ir_we_o, dmem_re_o, dmem_we_o, rf_we_o, pc_we_o, pc_src_o;
    logic [3:0]       MemtoReg;
    logic             storeJalr, wbToReg, selUtype, Branch, selJalOrJalr, trap_o;
    logic [CNT_W-1:0] instret_o;

    always #5 clk = ~clk;

    rv_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_i      (instr_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .ex_branch_i  (ex_branch_i),
        .imem_req_o   (imem_req_o),
        .ir_we_o      (ir_we_o),
        .dmem_re_o    (dmem_re_o),
        .dmem_we_o    (dmem_we_o),
        .rf_we_o      (rf_we_o),
        .pc_we_o      (pc_we_o),
        .pc_src_o     (pc_src_o),
        .MemtoReg     (MemtoReg),
        .storeJalr    (storeJalr),
        .wbToReg      (wbToReg),
        .selUtype     (selUtype),
        .Branch       (Branch),
        .selJalOrJalr (selJalOrJalr),
        .trap_o       (trap_o),
        .instret_o    (instret_o)
    );

    logic [16:0] all_out;
    logic [9:0]  sel_now;
    assign all_out = {imem_req_o, ir_we_o, dmem_re_o, dmem_we_o, rf_we_o, pc_we_o, pc_src_o,
                      MemtoReg, storeJalr, wbToReg, selUtype, Branch, selJalOrJalr, trap_o};
    assign sel_now = {MemtoReg, storeJalr, wbToReg, selUtype, Branch, selJalOrJalr, pc_src_o};

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        int         iw;
        int         dw;
        logic [9:0] sel;
        int         rf;
        int         lat;
        int         dre;
        int         dwe;
    } vec_t;

    vec_t vecs[16];

    int n_chk = 0;
    int n_pass = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    int         r_lat, r_dre, r_dwe, r_rf, r_irwe, r_rfwb;
    logic [9:0] r_sel_ex, r_sel_wb;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'h05a5a, f3, 5'b10101, op};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // one instruction from a FETCH-state negedge; returns on the negedge after WB
    task automatic run(input logic [31:0] ins, input int iwait, input int dwait);
        int mem_seen;
        mem_seen = 0;
        r_lat = 0; r_dre = 0; r_dwe = 0; r_rf = 0; r_irwe = 0; r_rfwb = 0;
        r_sel_ex = '0; r_sel_wb = '0;
        for (int k = 1; k <= 40; k++) begin
            instr_i      = ins;
            imem_ready_i = (k > iwait);
            dmem_ready_i = (mem_seen >= dwait);
            #1;
            if (dmem_re_o) r_dre++;
            if (dmem_we_o) r_dwe++;
            if (dmem_re_o || dmem_we_o) mem_seen++;
            if (rf_we_o) r_rf++;
            if (ir_we_o) r_irwe++;
            if (k == 3 + iwait) r_sel_ex = sel_now;
            if (pc_we_o) begin
                r_lat    = k;
                r_rfwb   = int'(rf_we_o);
                r_sel_wb = sel_now;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", 64'(all_out), 64'd0);
        chk("reset_instret", 64'(instret_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_idle", 64'(all_out), 64'd0);
        @(negedge clk);
        exp_instret = '0;
    endtask

    initial begin
        int tcnt, scnt;
        //        name    op          f3     iw dw  sel{mtr,sj,wb,su,br,sjj,pcs}  rf lat dre dwe
        vecs[0]  = '{"addi",  7'b0010011, 3'b000, 0, 0, 10'b0000_00000_0, 1, 4, 0, 0};
        vecs[1]  = '{"lui",   7'b0110111, 3'b000, 0, 0, 10'b0000_01000_0, 1, 4, 0, 0};
        vecs[2]  = '{"auipc", 7'b0010111, 3'b000, 0, 0, 10'b0000_01100_0, 1, 4, 0, 0};
        vecs[3]  = '{"jal",   7'b1101111, 3'b000, 0, 0, 10'b0000_10000_1, 1, 4, 0, 0};
        vecs[4]  = '{"jalr",  7'b1100111, 3'b000, 0, 0, 10'b0000_10001_1, 1, 4, 0, 0};
        vecs[5]  = '{"beq",   7'b1100011, 3'b000, 0, 0, 10'b0000_00010_0, 0, 4, 0, 0};
        vecs[6]  = '{"lb",    7'b0000011, 3'b000, 0, 0, 10'b0001_00000_0, 1, 5, 1, 0};
        vecs[7]  = '{"lh",    7'b0000011, 3'b001, 0, 0, 10'b0011_00000_0, 1, 5, 1, 0};
        vecs[8]  = '{"lw",    7'b0000011, 3'b010, 0, 0, 10'b0101_00000_0, 1, 5, 1, 0};
        vecs[9]  = '{"lbu",   7'b0000011, 3'b100, 0, 0, 10'b1001_00000_0, 1, 5, 1, 0};
        vecs[10] = '{"lhu",   7'b0000011, 3'b101, 0, 0, 10'b1011_00000_0, 1, 5, 1, 0};
        vecs[11] = '{"sw",    7'b0100011, 3'b010, 0, 0, 10'b0000_00000_0, 0, 5, 0, 1};
        vecs[12] = '{"add",   7'b0110011, 3'b000, 0, 0, 10'b0000_00000_0, 1, 4, 0, 0};
        vecs[13] = '{"addi_iw2", 7'b0010011, 3'b000, 2, 0, 10'b0000_00000_0, 1, 6, 0, 0};
        vecs[14] = '{"lhu_dw3",  7'b0000011, 3'b101, 0, 3, 10'b1011_00000_0, 1, 8, 4, 0};
        vecs[15] = '{"sw_dw1",   7'b0100011, 3'b010, 0, 1, 10'b0000_00000_0, 0, 6, 0, 2};

        #2;
        chk("por_outputs", 64'(all_out), 64'd0);
        chk("por_instret", 64'(instret_o), 64'd0);
        @(negedge clk);
        do_reset();

        // table of single instructions, back to back
        for (int i = 0; i < 16; i++) begin
            run(mk(vecs[i].op, vecs[i].f3), vecs[i].iw, vecs[i].dw);
            exp_instret = exp_instret + 1'b1;
            chk({vecs[i].name, "_latency"}, 64'(r_lat), 64'(vecs[i].lat));
            chk({vecs[i].name, "_rf_we_wb"}, 64'(r_rfwb), 64'(vecs[i].rf));
            chk({vecs[i].name, "_rf_we_count"}, 64'(r_rf), 64'(vecs[i].rf));
            chk({vecs[i].name, "_sel_wb"}, 64'(r_sel_wb), 64'(vecs[i].sel));
            chk({vecs[i].name, "_sel_exec"}, 64'(r_sel_ex), 64'(vecs[i].sel));
            chk({vecs[i].name, "_dmem_re"}, 64'(r_dre), 64'(vecs[i].dre));
            chk({vecs[i].name, "_dmem_we"}, 64'(r_dwe), 64'(vecs[i].dwe));
            chk({vecs[i].name, "_ir_we"}, 64'(r_irwe), 64'd1);
            chk({vecs[i].name, "_instret"}, 64'(instret_o), 64'(exp_instret));
        end

        // illegal opcode: trap absorbs further instructions
        tcnt = 0; scnt = 0;
        imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
        instr_i = mk(7'b1111111, 3'b000);
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (k >= 3) begin
                if (trap_o) tcnt++;
                scnt += int'(imem_req_o) + int'(ir_we_o) + int'(dmem_re_o) + int'(dmem_we_o)
                      + int'(rf_we_o) + int'(pc_we_o);
            end
            @(negedge clk);
            instr_i = mk(7'b0010011, 3'b000);
        end
        chk("trap_cycles", 64'(tcnt), 64'd10);
        chk("trap_strobes", 64'(scnt), 64'd0);
        chk("trap_instret", 64'(instret_o), 64'(exp_instret));
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        do_reset();

        // load with reserved funct3 also traps
        imem_ready_i = 1'b1;
        instr_i = mk(7'b0000011, 3'b011);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("load_f3_trap", 64'(trap_o), 64'd1);
        chk("load_f3_trap_sel", 64'(sel_now), 64'd0);
        imem_ready_i = 1'b0;
        do_reset();

        // asynchronous reset in the middle of a load's MEM phase
        run(mk(7'b0010011, 3'b000), 0, 0);
        exp_instret = exp_instret + 1'b1;
        chk("pre_abort_instret", 64'(instret_o), 64'(exp_instret));
        imem_ready_i = 1'b1; dmem_ready_i = 1'b0;
        instr_i = mk(7'b0000011, 3'b010);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) @(negedge clk);
        end
        #1;
        chk("abort_in_mem", 64'(dmem_re_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'(all_out), 64'd0);
        chk("abort_instret", 64'(instret_o), 64'd0);
        @(negedge clk);
        chk("abort_no_rf_we", 64'(rf_we_o), 64'd0);
        rst_n = 1'b1;
        imem_ready_i = 1'b0;
        #1;
        chk("abort_release_idle", 64'(all_out), 64'd0);
        @(negedge clk);
        exp_instret = '0;
        run(mk(7'b0010011, 3'b000), 0, 0);
        exp_instret = exp_instret + 1'b1;
        chk("restart_latency", 64'(r_lat), 64'd4);
        chk("restart_instret", 64'(instret_o), 64'(exp_instret));

        // counter wrap from all-ones
        force dut.instret_q = '1;
        #1;
        release dut.instret_q;
        chk("wrap_preload", 64'(instret_o), 64'({CNT_W{1'b1}}));
        run(mk(7'b0110111, 3'b000), 0, 0);
        chk("wrap_latency", 64'(r_lat), 64'd4);
        chk("wrap_instret", 64'(instret_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
